// File: rtl/shift_add_mult_if.sv
// Bundle of the multiplier's request/result handshake and its link to the external ripple-carry adder.
// The master side issues requests and hosts the combinational adder; the slave side is the multiplier.
interface shift_add_mult_if #(parameter int WIDTH = 4);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic                 add_cin;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;

  modport master (
    output start, multiplicand, multiplier, add_sum, add_cout,
    input  busy, done, product, add_a, add_b, add_cin
  );

  modport slave (
    input  start, multiplicand, multiplier, add_sum, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier that retires one multiplier bit per clock,
// using an external combinational adder for the A + M partial sums.
module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  shift_add_mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     m;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_r;

  logic                 carry;
  logic [WIDTH-1:0]     a_sel;
  logic [WIDTH-1:0]     a_next;
  logic [WIDTH-1:0]     q_next;

  assign bus.add_a   = a;
  assign bus.add_b   = m;
  assign bus.add_cin = 1'b0;
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product_r;

  // The adder's carry-out becomes the new A MSB on the shift, so no product bit is ever lost.
  always_comb begin
    carry = 1'b0;
    a_sel = a;
    if (q[0]) begin
      carry = bus.add_cout;
      a_sel = bus.add_sum;
    end
  end

  assign a_next = {carry, a_sel[WIDTH-1:1]};
  assign q_next = {a_sel[0], q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m     <= bus.multiplicand;
            q     <= bus.multiplier;
            a     <= '0;
            cnt   <= CW'(WIDTH);
            state <= RUN;
          end
        end
        RUN: begin
          a         <= a_next;
          q         <= q_next;
          product_r <= {a_next, q_next};
          cnt       <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          // A request in the result cycle is accepted so results can stream back to back.
          if (bus.start) begin
            m     <= bus.multiplicand;
            q     <= bus.multiplier;
            a     <= '0;
            cnt   <= CW'(WIDTH);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: 4-bit and 8-bit instances, each paired with a behavioural adder,
// checked against plain multiplication and the start-to-done timing rules.
module tb_shift_add_mult;

  logic clk;
  logic rst_n;
  int   ntests;
  int   nfail;

  shift_add_mult_if #(.WIDTH(4)) b4 ();
  shift_add_mult_if #(.WIDTH(8)) b8 ();

  shift_add_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  shift_add_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  assign {b4.add_cout, b4.add_sum} = {1'b0, b4.add_a} + {1'b0, b4.add_b} + 5'(b4.add_cin);
  assign {b8.add_cout, b8.add_sum} = {1'b0, b8.add_a} + {1'b0, b8.add_b} + 9'(b8.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one 4-bit multiply (or picks up one already accepted when pre=1) and observes it to done.
  task automatic do_op(input bit pre, input logic [3:0] m, input logic [3:0] q,
                       input bit chain, input logic [3:0] nm, input logic [3:0] nq,
                       output int busy_c, output int lat, output logic [7:0] prod,
                       output bit to, output bit addb_bad, output bit cout_seen);
    busy_c = 0; lat = 0; prod = '0; to = 1'b1; addb_bad = 1'b0; cout_seen = 1'b0;
    if (!pre) begin
      @(negedge clk);
      b4.start = 1'b1; b4.multiplicand = m; b4.multiplier = q;
    end
    @(negedge clk);
    b4.start = 1'b0;
    b4.multiplicand = 4'($urandom);
    b4.multiplier = 4'($urandom);
    for (int k = 1; k <= 10; k++) begin
      if (b4.busy === 1'b1) begin
        busy_c++;
        if (b4.add_b !== m) addb_bad = 1'b1;
        if (b4.add_cout === 1'b1) cout_seen = 1'b1;
      end
      if (b4.done === 1'b1) begin
        lat = k; prod = b4.product; to = 1'b0;
        if (chain) begin
          b4.start = 1'b1; b4.multiplicand = nm; b4.multiplier = nq;
        end
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b4.start = 1'b0; b4.multiplicand = '0; b4.multiplier = '0;
    b8.start = 1'b0; b8.multiplicand = '0; b8.multiplier = '0;
    #1;
    ntests++;
    if (b4.busy !== 1'b0 || b4.done !== 1'b0) begin
      nfail++; $display("[TB] FAIL reset_flags: busy=%b done=%b expected 0 0", b4.busy, b4.done);
    end
    ntests++;
    if (b4.product !== 8'd0) begin
      nfail++; $display("[TB] FAIL reset_product: got %0d expected 0", b4.product);
    end
    ntests++;
    if (b4.add_a !== 4'd0 || b4.add_b !== 4'd0 || b4.add_cin !== 1'b0) begin
      nfail++; $display("[TB] FAIL reset_adder_ins: a=%0d b=%0d cin=%b expected 0 0 0", b4.add_a, b4.add_b, b4.add_cin);
    end
    ntests++;
    if (b8.busy !== 1'b0 || b8.done !== 1'b0 || b8.product !== 16'd0) begin
      nfail++; $display("[TB] FAIL reset_wide: busy=%b done=%b product=%0d expected 0 0 0", b8.busy, b8.done, b8.product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int busy_c, lat; logic [7:0] prod; bit to, addb_bad, cout_seen;
    do_op(1'b0, 4'd3, 4'd5, 1'b0, 4'd0, 4'd0, busy_c, lat, prod, to, addb_bad, cout_seen);
    ntests++;
    if (to || prod !== 8'd15) begin
      nfail++; $display("[TB] FAIL basic_product: got %0d (timeout=%b) expected 15", prod, to);
    end
    ntests++;
    if (busy_c != 4 || lat != 5) begin
      nfail++; $display("[TB] FAIL basic_timing: busy=%0d done_at=%0d expected 4 5", busy_c, lat);
    end
    ntests++;
    if (addb_bad) begin
      nfail++; $display("[TB] FAIL basic_add_b: add_b left 3 during RUN, expected 3");
    end
    @(negedge clk);
    ntests++;
    if (b4.done !== 1'b0 || b4.busy !== 1'b0 || b4.product !== 8'd15) begin
      nfail++; $display("[TB] FAIL basic_idle_hold: done=%b busy=%b product=%0d expected 0 0 15", b4.done, b4.busy, b4.product);
    end
  endtask

  task automatic test_max();
    int busy_c, lat; logic [7:0] prod; bit to, addb_bad, cout_seen;
    do_op(1'b0, 4'd15, 4'd15, 1'b0, 4'd0, 4'd0, busy_c, lat, prod, to, addb_bad, cout_seen);
    ntests++;
    if (to || prod !== 8'hE1) begin
      nfail++; $display("[TB] FAIL max_product: got %0d (timeout=%b) expected 225", prod, to);
    end
    ntests++;
    if (!cout_seen) begin
      nfail++; $display("[TB] FAIL max_cout: add_cout never 1 during RUN, expected at least once");
    end
  endtask

  task automatic test_zero();
    int busy_c, lat; logic [7:0] prod; bit to, addb_bad, cout_seen;
    do_op(1'b0, 4'd0, 4'd9, 1'b0, 4'd0, 4'd0, busy_c, lat, prod, to, addb_bad, cout_seen);
    ntests++;
    if (to || prod !== 8'd0 || busy_c != 4 || lat != 5) begin
      nfail++; $display("[TB] FAIL zero_m: product=%0d busy=%0d done_at=%0d expected 0 4 5", prod, busy_c, lat);
    end
    do_op(1'b0, 4'd9, 4'd0, 1'b0, 4'd0, 4'd0, busy_c, lat, prod, to, addb_bad, cout_seen);
    ntests++;
    if (to || prod !== 8'd0 || busy_c != 4 || lat != 5) begin
      nfail++; $display("[TB] FAIL zero_q: product=%0d busy=%0d done_at=%0d expected 0 4 5", prod, busy_c, lat);
    end
  endtask

  task automatic test_ignore_start();
    int busy_c; logic [7:0] prod; bit to;
    busy_c = 0; prod = '0; to = 1'b1;
    @(negedge clk);
    b4.start = 1'b1; b4.multiplicand = 4'd3; b4.multiplier = 4'd5;
    @(negedge clk);
    b4.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      b4.start = (k == 2);
      if (k == 2) begin b4.multiplicand = 4'd7; b4.multiplier = 4'd7; end
      if (b4.busy === 1'b1) busy_c++;
      if (b4.done === 1'b1) begin prod = b4.product; to = 1'b0; b4.start = 1'b0; break; end
      @(negedge clk);
    end
    b4.start = 1'b0;
    ntests++;
    if (to || prod !== 8'd15 || busy_c != 4) begin
      nfail++; $display("[TB] FAIL ignore_start: product=%0d busy=%0d expected 15 4", prod, busy_c);
    end
  endtask

  task automatic test_reset_mid();
    int busy_c, lat; logic [7:0] prod; bit to, addb_bad, cout_seen;
    @(negedge clk);
    b4.start = 1'b1; b4.multiplicand = 4'd6; b4.multiplier = 4'd6;
    @(negedge clk);
    b4.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    ntests++;
    if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.product !== 8'd0) begin
      nfail++; $display("[TB] FAIL reset_mid: busy=%b done=%b product=%0d expected 0 0 0", b4.busy, b4.done, b4.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 4'd2, 4'd3, 1'b0, 4'd0, 4'd0, busy_c, lat, prod, to, addb_bad, cout_seen);
    ntests++;
    if (to || prod !== 8'd6 || busy_c != 4 || lat != 5) begin
      nfail++; $display("[TB] FAIL reset_recover: product=%0d busy=%0d done_at=%0d expected 6 4 5", prod, busy_c, lat);
    end
  endtask

  task automatic test_back_to_back();
    int busy_c, lat; logic [7:0] prod; bit to, addb_bad, cout_seen;
    do_op(1'b0, 4'd3, 4'd5, 1'b1, 4'd4, 4'd4, busy_c, lat, prod, to, addb_bad, cout_seen);
    ntests++;
    if (to || prod !== 8'd15) begin
      nfail++; $display("[TB] FAIL b2b_first: got %0d expected 15", prod);
    end
    @(negedge clk);
    b4.start = 1'b0;
    ntests++;
    if (b4.done !== 1'b0 || b4.busy !== 1'b1) begin
      nfail++; $display("[TB] FAIL b2b_pulse: done=%b busy=%b expected 0 1", b4.done, b4.busy);
    end
    busy_c = 0; to = 1'b1; prod = '0;
    for (int k = 1; k <= 10; k++) begin
      if (b4.busy === 1'b1) busy_c++;
      if (b4.done === 1'b1) begin prod = b4.product; to = 1'b0; break; end
      @(negedge clk);
    end
    ntests++;
    if (to || prod !== 8'd16 || busy_c != 4) begin
      nfail++; $display("[TB] FAIL b2b_second: product=%0d busy=%0d expected 16 4", prod, busy_c);
    end
  endtask

  task automatic test_random();
    int busy_c, lat; logic [7:0] prod; bit to, addb_bad, cout_seen;
    logic [3:0] m, q, nm, nq;
    bit chained;
    chained = 1'b0; nm = '0; nq = '0;
    for (int i = 0; i < 24; i++) begin
      m = chained ? nm : 4'($urandom);
      q = chained ? nq : 4'($urandom);
      nm = 4'($urandom); nq = 4'($urandom);
      do_op(chained, m, q, (i % 3 == 1), nm, nq, busy_c, lat, prod, to, addb_bad, cout_seen);
      ntests++;
      if (to || prod !== 8'(m * q) || busy_c != 4 || lat != 5 || addb_bad) begin
        nfail++;
        $display("[TB] FAIL random_%0d: %0d*%0d product=%0d busy=%0d done_at=%0d expected %0d 4 5", i, m, q, prod, busy_c, lat, m * q);
      end
      chained = (i % 3 == 1);
    end
    b4.start = 1'b0;
  endtask

  task automatic test_wide();
    logic [7:0] m, q; logic [15:0] prod; int busy_c, lat; bit to;
    for (int i = 0; i < 5; i++) begin
      m = (i == 0) ? 8'd255 : 8'($urandom);
      q = (i == 0) ? 8'd255 : 8'($urandom);
      busy_c = 0; lat = 0; prod = '0; to = 1'b1;
      @(negedge clk);
      b8.start = 1'b1; b8.multiplicand = m; b8.multiplier = q;
      @(negedge clk);
      b8.start = 1'b0; b8.multiplicand = 8'($urandom); b8.multiplier = 8'($urandom);
      for (int k = 1; k <= 14; k++) begin
        if (b8.busy === 1'b1) busy_c++;
        if (b8.done === 1'b1) begin lat = k; prod = b8.product; to = 1'b0; break; end
        @(negedge clk);
      end
      ntests++;
      if (to || prod !== 16'(m * q) || busy_c != 8 || lat != 9) begin
        nfail++;
        $display("[TB] FAIL wide_%0d: %0d*%0d product=%0d busy=%0d done_at=%0d expected %0d 8 9", i, m, q, prod, busy_c, lat, 32'(m) * 32'(q));
      end
    end
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
